// File: rtl/frame_sequencer_pkg.sv
// Shared MFCC framing types: sequencer states, frame configuration record and
// the legality rule applied to a configuration at the enable edge.
package frame_sequencer_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_MAX_FRAME = 256;
    localparam int CFG_W         = 9;
    localparam int IDX_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] frame_len;
        logic [CFG_W-1:0] hop;
    } frame_cfg_t;

    function automatic logic cfg_legal(input frame_cfg_t cfg, input int max_len);
        return (cfg.frame_len >= CFG_W'(2)) && (cfg.frame_len <= CFG_W'(max_len)) &&
               (cfg.hop >= CFG_W'(1)) && (cfg.hop <= cfg.frame_len);
    endfunction

endpackage

// File: rtl/frame_ring_ptr.sv
// Write/frame pointers of the circular sample RAM; occupancy gates s_ready so
// the frame still being replayed can never be overwritten.
module frame_ring_ptr
    import frame_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              s_valid,
    input  logic              advance,
    input  logic [CFG_W-1:0]  hop,
    output logic              s_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [ADDR_W-1:0] rd_base,
    output logic [ADDR_W:0]   occ
);

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] fptr_q, fptr_d;

    // Extra pointer bit distinguishes full (occ == DEPTH) from empty.
    assign occ       = wptr_q - fptr_q;
    assign s_ready   = run && !occ[ADDR_W];
    assign buf_we    = s_valid && s_ready;
    assign buf_waddr = wptr_q[ADDR_W-1:0];
    assign rd_base   = fptr_q[ADDR_W-1:0];

    always_comb begin
        wptr_d = wptr_q;
        fptr_d = fptr_q;
        if (!run) begin
            wptr_d = '0;
            fptr_d = '0;
        end else begin
            if (buf_we) begin
                wptr_d = wptr_q + (ADDR_W+1)'(1);
            end
            if (advance) begin
                fptr_d = fptr_q + (ADDR_W+1)'(hop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            fptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            fptr_q <= fptr_d;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// MFCC framing sequencer: buffers samples in an external ring RAM and replays
// each complete frame as a ready/valid stream tagged with its in-frame index.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_FRAME = DEF_MAX_FRAME
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CFG_W-1:0]  cfg_frame_len,
    input  logic [CFG_W-1:0]  cfg_hop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              buf_re,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_first,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       frame_cnt,
    output logic              cfg_err
);

    seq_state_t        state_q, state_d;
    frame_cfg_t        cfg_q, cfg_d;
    frame_cfg_t        cfg_in;
    logic              enable_q, enable_d;
    logic [CFG_W-1:0]  rd_idx_q, rd_idx_d;
    logic              m_valid_q, m_valid_d;
    logic [IDX_W-1:0]  m_idx_q, m_idx_d;
    logic              m_first_q, m_first_d;
    logic              m_last_q, m_last_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              cfg_err_q, cfg_err_d;

    logic              run;
    logic              issue;
    logic              advance;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   occ;

    assign cfg_in  = '{frame_len: cfg_frame_len, hop: cfg_hop};
    assign run     = (state_q != ST_IDLE);
    // A read is issued only when the output register is free or draining this cycle.
    assign issue   = (state_q == ST_EMIT) && (rd_idx_q < cfg_q.frame_len) && (!m_valid_q || m_ready);
    assign advance = m_valid_q && m_ready && m_last_q;

    frame_ring_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .s_valid   (s_valid),
        .advance   (advance),
        .hop       (cfg_q.hop),
        .s_ready   (s_ready),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .rd_base   (rd_base),
        .occ       (occ)
    );

    assign buf_wdata = s_data;
    assign buf_re    = issue;
    assign buf_raddr = rd_base + ADDR_W'(rd_idx_q);
    assign m_valid   = m_valid_q;
    assign m_data    = m_valid_q ? buf_rdata : '0;
    assign m_idx     = m_idx_q;
    assign m_first   = m_first_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_cnt_q;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        enable_d    = enable;
        rd_idx_d    = rd_idx_q;
        m_valid_d   = m_valid_q;
        m_idx_d     = m_idx_q;
        m_first_d   = m_first_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        cfg_err_d   = 1'b0;

        if (issue) begin
            m_valid_d = 1'b1;
            m_idx_d   = rd_idx_q[IDX_W-1:0];
            m_first_d = (rd_idx_q == '0);
            m_last_d  = (rd_idx_q == cfg_q.frame_len - CFG_W'(1));
            rd_idx_d  = rd_idx_q + CFG_W'(1);
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && !enable_q) begin
                    if (cfg_legal(cfg_in, MAX_FRAME)) begin
                        cfg_d   = cfg_in;
                        state_d = ST_FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (occ >= (ADDR_W+1)'(cfg_q.frame_len)) begin
                    state_d  = ST_EMIT;
                    rd_idx_d = '0;
                end
            end
            ST_EMIT: begin
                if (advance) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    rd_idx_d    = '0;
                    state_d     = enable ? ST_FILL : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            enable_q    <= 1'b0;
            rd_idx_q    <= '0;
            m_valid_q   <= 1'b0;
            m_idx_q     <= '0;
            m_first_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            enable_q    <= enable_d;
            rd_idx_q    <= rd_idx_d;
            m_valid_q   <= m_valid_d;
            m_idx_q     <= m_idx_d;
            m_first_q   <= m_first_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: ring RAM model, directed scenarios plus random
// configurations, output stream compared with frames cut from the fed samples.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [8:0]  cfg_frame_len;
    logic [8:0]  cfg_hop;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        buf_we;
    logic [8:0]  buf_waddr;
    logic [15:0] buf_wdata;
    logic        buf_re;
    logic [8:0]  buf_raddr;
    logic [15:0] buf_rdata;
    logic        m_valid;
    logic [15:0] m_data;
    logic [7:0]  m_idx;
    logic        m_first;
    logic        m_last;
    logic        m_ready;
    logic [15:0] frame_cnt;
    logic        cfg_err;

    always #5 clk = ~clk;

    frame_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_frame_len (cfg_frame_len),
        .cfg_hop       (cfg_hop),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .buf_we        (buf_we),
        .buf_waddr     (buf_waddr),
        .buf_wdata     (buf_wdata),
        .buf_re        (buf_re),
        .buf_raddr     (buf_raddr),
        .buf_rdata     (buf_rdata),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_idx         (m_idx),
        .m_first       (m_first),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .frame_cnt     (frame_cnt),
        .cfg_err       (cfg_err)
    );

    // External sample RAM: registered read, output held while buf_re is low.
    logic [15:0] ram [0:511];
    logic [15:0] rdata_q;
    always @(posedge clk) begin
        if (buf_we) ram[buf_waddr] <= buf_wdata;
        if (buf_re) rdata_q <= ram[buf_raddr];
    end
    assign buf_rdata = rdata_q;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  idx;
        logic        f;
        logic        l;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] samples [0:1023];
    int          feed_idx, feed_total, accepted;
    bit          feed_en;
    int          rdy_mode;
    beat_t       got [$];
    bit          stalled;
    logic [15:0] st_d;
    logic [7:0]  st_idx;
    int          err_pulses, mv_seen, we_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, drive inputs 1 after the rising edge.
    task automatic tick();
        bit acc_now;
        @(negedge clk);
        if (stalled) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {16'd0, m_data}, {16'd0, st_d});
            chk("stall_idx", {24'd0, m_idx}, {24'd0, st_idx});
        end
        stalled = m_valid && !m_ready;
        st_d    = m_data;
        st_idx  = m_idx;
        if (m_valid && m_ready) got.push_back('{m_data, m_idx, m_first, m_last});
        acc_now = s_valid && s_ready;
        if (acc_now) accepted++;
        if (cfg_err) err_pulses++;
        if (m_valid) mv_seen++;
        if (buf_we) we_seen++;
        @(posedge clk);
        #1;
        if (acc_now) feed_idx++;
        s_valid = feed_en && (feed_idx < feed_total);
        s_data  = s_valid ? samples[feed_idx] : 16'd0;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic gen_samples();
        for (int i = 0; i < 1024; i++) samples[i] = 16'($urandom);
    endtask

    task automatic start_run(input int len, input int hop, input int n, input int mode);
        feed_en = 1'b0;
        enable  = 1'b0;
        tick();
        tick();
        feed_idx   = 0;
        feed_total = n;
        accepted   = 0;
        err_pulses = 0;
        got.delete();
        cfg_frame_len = 9'(len);
        cfg_hop       = 9'(hop);
        rdy_mode      = mode;
        enable        = 1'b1;
        feed_en       = 1'b1;
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n = 0;
        while (frame_cnt !== 16'(target) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {16'd0, frame_cnt}, 32'(target));
    endtask

    task automatic stop_run();
        int n = 0;
        enable   = 1'b0;
        rdy_mode = 1;
        m_ready  = 1'b1;
        while (!(s_ready === 1'b0 && m_valid === 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        feed_en = 1'b0;
        chk("stop_idle_s_ready", {31'd0, s_ready}, 32'd0);
    endtask

    // Reference: frame k covers fed samples k*hop .. k*hop+len-1, if all are available.
    task automatic compare_stream(input string tag, input int len, input int hop,
                                  input int navail, input int max_frames);
        int    nf;
        int    pos;
        int    e0;
        beat_t exp;
        nf = (navail >= len) ? ((navail - len) / hop + 1) : 0;
        if (nf > max_frames) nf = max_frames;
        chk({tag, "_beats"}, 32'(got.size()), 32'(nf * len));
        pos = 0;
        e0  = errors;
        for (int k = 0; k < nf; k++) begin
            for (int i = 0; i < len; i++) begin
                if (pos >= got.size()) return;
                exp = '{samples[k*hop+i], 8'(i), (i == 0), (i == len - 1)};
                chk({tag, "_beat"}, {6'd0, got[pos]}, {6'd0, exp});
                pos++;
                if (errors != e0) return;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_s_ready"},   {31'd0, s_ready},   32'd0);
        chk({tag, "_buf_we"},    {31'd0, buf_we},    32'd0);
        chk({tag, "_buf_waddr"}, {23'd0, buf_waddr}, 32'd0);
        chk({tag, "_buf_re"},    {31'd0, buf_re},    32'd0);
        chk({tag, "_buf_raddr"}, {23'd0, buf_raddr}, 32'd0);
        chk({tag, "_m_valid"},   {31'd0, m_valid},   32'd0);
        chk({tag, "_m_data"},    {16'd0, m_data},    32'd0);
        chk({tag, "_m_idx"},     {24'd0, m_idx},     32'd0);
        chk({tag, "_m_first"},   {31'd0, m_first},   32'd0);
        chk({tag, "_m_last"},    {31'd0, m_last},    32'd0);
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
        chk({tag, "_cfg_err"},   {31'd0, cfg_err},   32'd0);
    endtask

    initial begin
        int base;
        int len, hop, n, nf;
        int found;
        rst_n = 1'b0; enable = 1'b0; cfg_frame_len = '0; cfg_hop = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        feed_en = 1'b0; feed_idx = 0; feed_total = 0; accepted = 0;
        rdy_mode = 1; stalled = 1'b0; err_pulses = 0; mv_seen = 0; we_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1) len 8 hop 4, 16 samples, always ready.
        gen_samples();
        start_run(8, 4, 16, 1);
        wait_frames("t1_frames", 3, 300);
        repeat (4) tick();
        compare_stream("t1", 8, 4, 16, 99);
        chk("t1_accepted", 32'(accepted), 32'd16);
        stop_run();

        // 2) same samples, random backpressure.
        start_run(8, 4, 16, 2);
        wait_frames("t2_frames", 6, 600);
        repeat (4) tick();
        compare_stream("t2", 8, 4, 16, 99);

        stop_run();

        // 3) len 256 hop 256 with the sink stalled: buffer fills to depth exactly.
        gen_samples();
        base = int'(frame_cnt);
        start_run(256, 256, 600, 0);
        repeat (800) tick();
        chk("t3_accepted_full", 32'(accepted), 32'd512);
        chk("t3_s_ready_full", {31'd0, s_ready}, 32'd0);
        chk("t3_m_valid_held", {31'd0, m_valid}, 32'd1);
        rdy_mode = 1;
        wait_frames("t3_frames", base + 2, 3000);
        repeat (4) tick();
        chk("t3_s_ready_back", {31'd0, s_ready}, 32'd1);
        repeat (100) tick();
        chk("t3_accepted_all", 32'(accepted), 32'd600);
        compare_stream("t3", 256, 256, 600, 99);
        stop_run();

        // 4) illegal configurations at the enable edge.
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       begin len = 8;   hop = 0; end
                1:       begin len = 1;   hop = 1; end
                2:       begin len = 8;   hop = 9; end
                default: begin len = 257; hop = 1; end
            endcase
            start_run(len, hop, 10, 1);
            mv_seen = 0;
            we_seen = 0;
            repeat (6) tick();
            chk($sformatf("t4_cfg_err_%0d", c), 32'(err_pulses), 32'd1);
            chk($sformatf("t4_no_we_%0d", c), 32'(we_seen), 32'd0);
            chk($sformatf("t4_no_mvalid_%0d", c), 32'(mv_seen), 32'd0);
            chk($sformatf("t4_s_ready_%0d", c), {31'd0, s_ready}, 32'd0);
            enable  = 1'b0;
            feed_en = 1'b0;
        end

        // 5) len 8 hop 2, enable dropped at m_idx 3 of the first frame.
        gen_samples();
        base = int'(frame_cnt);
        start_run(8, 2, 32, 1);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (m_valid === 1'b1 && m_idx === 8'd3) found = 1;
        end
        chk("t5_reached_idx3", 32'(found), 32'd1);
        enable = 1'b0;
        mv_seen = 0;
        repeat (60) tick();
        compare_stream("t5", 8, 2, 32, 1);
        chk("t5_frames", {16'd0, frame_cnt}, 32'(base + 1));
        chk("t5_s_ready", {31'd0, s_ready}, 32'd0);
        chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
        feed_en = 1'b0;

        // 6) reset at m_idx 5 of the second frame, then rerun scenario 1.
        gen_samples();
        base = int'(frame_cnt);
        start_run(8, 4, 16, 1);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (frame_cnt === 16'(base + 1) && m_valid === 1'b1 && m_idx === 8'd5) found = 1;
        end
        chk("t6_reached_idx5", 32'(found), 32'd1);
        rst_n   = 1'b0;
        enable  = 1'b0;
        feed_en = 1'b0;
        stalled = 1'b0;
        tick();
        check_idle_outputs("t6_reset");
        rst_n = 1'b1;
        tick();
        start_run(8, 4, 16, 1);
        wait_frames("t6_frames", 3, 300);
        repeat (4) tick();
        compare_stream("t6", 8, 4, 16, 99);
        stop_run();

        // 7) random legal configurations with random backpressure.
        for (int r = 0; r < 5; r++) begin
            gen_samples();
            case (r)
                0:       begin len = 2;  hop = 1; end
                1:       begin len = 16; hop = 16; end
                default: begin
                    len = int'($urandom_range(2, 20));
                    hop = int'($urandom_range(1, len));
                end
            endcase
            n    = int'($urandom_range(len, 64));
            nf   = (n - len) / hop + 1;
            base = int'(frame_cnt);
            start_run(len, hop, n, 2);
            wait_frames($sformatf("t7_frames_%0d", r), base + nf, 4000);
            repeat (6) tick();
            compare_stream($sformatf("t7_%0d", r), len, hop, n, 999);
            chk($sformatf("t7_no_cfg_err_%0d", r), 32'(err_pulses), 32'd0);
            stop_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
